// File: rtl/decode.sv
// RV64I decode stage: registered decode of one instruction per cycle with load-use bubble insertion.
// Optional DECODE_WORD_OPS_EN enables OP-IMM-32 / OP-32 decode and the word_out flag.
module decode (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        instr_valid_in,
  input  logic [31:0] instr_in,
  input  logic [63:0] pc_in,
  output logic [8:0]  rs1_out,
  output logic [8:0]  rs2_out,
  output logic        stall_out,
  output logic        valid_out,
  output logic [63:0] pc_out,
  output logic [8:0]  rd_out,
  output logic        rd_write_out,
  output logic [63:0] imm_out,
  output logic [3:0]  alu_op_out,
  output logic [2:0]  funct3_out,
  output logic        src1_pc_out,
  output logic        src2_imm_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        branch_out,
  output logic        jump_out,
  output logic        word_out,
  output logic        illegal_out
);

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
`ifdef DECODE_WORD_OPS_EN
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP_OP32    = 7'b0111011;
`endif

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Instruction bit 30 selects SUB only for register ops; for immediates it is an imm bit except on shifts.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic b30, input logic is_reg);
    case (f3)
      3'b000:  alu_sel = (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      3'b111:  alu_sel = ALU_AND;
      default: alu_sel = ALU_ADD;
    endcase
  endfunction

  logic [6:0]  w_opcode;
  logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
  logic        w_legal, w_writes, w_use_rs1, w_use_rs2;
  logic        w_src1_pc, w_src2_imm, w_mem_read, w_mem_write, w_branch, w_jump;
  logic [3:0]  w_alu;
  logic        w_hazard, w_bubble;

  logic        r_valid, r_rd_write, r_src1_pc, r_src2_imm;
  logic        r_mem_read, r_mem_write, r_branch, r_jump, r_illegal;
  logic [63:0] r_pc, r_imm;
  logic [4:0]  r_rd;
  logic [3:0]  r_alu;
  logic [2:0]  r_funct3;

  assign w_opcode = instr_in[6:0];
  assign w_imm_i  = {{52{instr_in[31]}}, instr_in[31:20]};
  assign w_imm_s  = {{52{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign w_imm_b  = {{51{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
  assign w_imm_u  = {{32{instr_in[31]}}, instr_in[31:12], 12'h000};
  assign w_imm_j  = {{43{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

  assign rs1_out  = {4'd0, instr_in[19:15]};
  assign rs2_out  = {4'd0, instr_in[24:20]};

`ifdef DECODE_WORD_OPS_EN
  logic w_word, r_word;
`endif

  // Opcode class decode; unknown opcodes (including bits[1:0]!=11) stay at the illegal defaults.
  always_comb begin
    w_legal     = 1'b0;
    w_writes    = 1'b0;
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_imm       = 64'd0;
    w_alu       = ALU_ADD;
    w_src1_pc   = 1'b0;
    w_src2_imm  = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
`ifdef DECODE_WORD_OPS_EN
    w_word      = 1'b0;
`endif
    case (w_opcode)
      OP_LUI:    begin w_legal = 1'b1; w_writes = 1'b1; w_imm = w_imm_u; w_src2_imm = 1'b1; end
      OP_AUIPC:  begin w_legal = 1'b1; w_writes = 1'b1; w_imm = w_imm_u; w_src1_pc = 1'b1; w_src2_imm = 1'b1; end
      OP_JAL:    begin w_legal = 1'b1; w_writes = 1'b1; w_imm = w_imm_j; w_src1_pc = 1'b1; w_src2_imm = 1'b1; w_jump = 1'b1; end
      OP_JALR:   begin w_legal = 1'b1; w_writes = 1'b1; w_imm = w_imm_i; w_src2_imm = 1'b1; w_jump = 1'b1; w_use_rs1 = 1'b1; end
      OP_BRANCH: begin w_legal = 1'b1; w_imm = w_imm_b; w_branch = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_LOAD:   begin w_legal = 1'b1; w_writes = 1'b1; w_imm = w_imm_i; w_src2_imm = 1'b1; w_mem_read = 1'b1; w_use_rs1 = 1'b1; end
      OP_STORE:  begin w_legal = 1'b1; w_imm = w_imm_s; w_src2_imm = 1'b1; w_mem_write = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_OPIMM:  begin
        w_legal = 1'b1; w_writes = 1'b1; w_imm = w_imm_i; w_src2_imm = 1'b1; w_use_rs1 = 1'b1;
        w_alu = alu_sel(instr_in[14:12], instr_in[30], 1'b0);
      end
      OP_OP:     begin
        w_legal = 1'b1; w_writes = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_alu = alu_sel(instr_in[14:12], instr_in[30], 1'b1);
      end
`ifdef DECODE_WORD_OPS_EN
      OP_OPIMM32: begin
        w_legal = 1'b1; w_writes = 1'b1; w_imm = w_imm_i; w_src2_imm = 1'b1; w_use_rs1 = 1'b1; w_word = 1'b1;
        w_alu = alu_sel(instr_in[14:12], instr_in[30], 1'b0);
      end
      OP_OP32:    begin
        w_legal = 1'b1; w_writes = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_word = 1'b1;
        w_alu = alu_sel(instr_in[14:12], instr_in[30], 1'b1);
      end
`endif
      default:   begin w_legal = 1'b0; end
    endcase
  end

  assign w_hazard  = r_valid && r_mem_read && (r_rd != 5'd0) && instr_valid_in &&
                     ((w_use_rs1 && (r_rd == instr_in[19:15])) || (w_use_rs2 && (r_rd == instr_in[24:20])));
  assign stall_out = !reset_in && !flush_in && (stall_in || w_hazard);
  // Flush wins over stall; a bubble clears every output so flags are 0 whenever valid_out is 0.
  assign w_bubble  = flush_in || (!stall_in && (w_hazard || !instr_valid_in));

  // Decode output register: clear on reset/bubble, hold on stall, otherwise capture.
  always_ff @(posedge clk) begin
    if (reset_in || w_bubble) begin
      r_valid <= 1'b0; r_pc <= 64'd0; r_rd <= 5'd0; r_rd_write <= 1'b0; r_imm <= 64'd0;
      r_alu <= 4'd0; r_funct3 <= 3'd0; r_src1_pc <= 1'b0; r_src2_imm <= 1'b0;
      r_mem_read <= 1'b0; r_mem_write <= 1'b0; r_branch <= 1'b0; r_jump <= 1'b0; r_illegal <= 1'b0;
`ifdef DECODE_WORD_OPS_EN
      r_word <= 1'b0;
`endif
    end else if (!stall_in) begin
      r_valid     <= 1'b1;
      r_pc        <= pc_in;
      r_rd        <= instr_in[11:7];
      r_rd_write  <= w_writes && (instr_in[11:7] != 5'd0);
      r_imm       <= w_imm;
      r_alu       <= w_alu;
      r_funct3    <= instr_in[14:12];
      r_src1_pc   <= w_src1_pc;
      r_src2_imm  <= w_src2_imm;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      r_branch    <= w_branch;
      r_jump      <= w_jump;
      r_illegal   <= !w_legal;
`ifdef DECODE_WORD_OPS_EN
      r_word      <= w_word;
`endif
    end
  end

  assign valid_out     = r_valid;
  assign pc_out        = r_pc;
  assign rd_out        = {4'd0, r_rd};
  assign rd_write_out  = r_rd_write;
  assign imm_out       = r_imm;
  assign alu_op_out    = r_alu;
  assign funct3_out    = r_funct3;
  assign src1_pc_out   = r_src1_pc;
  assign src2_imm_out  = r_src2_imm;
  assign mem_read_out  = r_mem_read;
  assign mem_write_out = r_mem_write;
  assign branch_out    = r_branch;
  assign jump_out      = r_jump;
  assign illegal_out   = r_illegal;
`ifdef DECODE_WORD_OPS_EN
  assign word_out      = r_word;
`else
  assign word_out      = 1'b0;
`endif

endmodule

// File: tb/tb_decode.sv
// Directed scoreboard bench for decode: per-edge expectations queued at drive time, checked after the edge.
module tb_decode;
  logic        clk = 1'b0;
  logic        reset_in, stall_in, flush_in, instr_valid_in;
  logic [31:0] instr_in;
  logic [63:0] pc_in;
  logic [8:0]  rs1_out, rs2_out, rd_out;
  logic        stall_out, valid_out, rd_write_out, src1_pc_out, src2_imm_out;
  logic        mem_read_out, mem_write_out, branch_out, jump_out, word_out, illegal_out;
  logic [63:0] pc_out, imm_out;
  logic [3:0]  alu_op_out;
  logic [2:0]  funct3_out;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .reset_in(reset_in), .stall_in(stall_in), .flush_in(flush_in),
    .instr_valid_in(instr_valid_in), .instr_in(instr_in), .pc_in(pc_in),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .stall_out(stall_out), .valid_out(valid_out),
    .pc_out(pc_out), .rd_out(rd_out), .rd_write_out(rd_write_out), .imm_out(imm_out),
    .alu_op_out(alu_op_out), .funct3_out(funct3_out), .src1_pc_out(src1_pc_out),
    .src2_imm_out(src2_imm_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .branch_out(branch_out), .jump_out(jump_out), .word_out(word_out), .illegal_out(illegal_out)
  );

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [8:0]  rd;
    logic        rdw;
    logic [63:0] imm;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic        s1pc;
    logic        s2imm;
    logic        mr, mw, br, j, w, ill;
  } out_t;

  typedef struct packed {
    out_t e;
    out_t m;
  } sb_t;

  out_t obs;
  assign obs = {valid_out, pc_out, rd_out, rd_write_out, imm_out, alu_op_out, funct3_out,
                src1_pc_out, src2_imm_out, mem_read_out, mem_write_out, branch_out,
                jump_out, word_out, illegal_out};

  sb_t  sb_q[$];
  out_t last_e, last_m;
  out_t m_full, m_flags, m_noalu_rd, m_amb, zero;
  int   total = 0;
  int   passed = 0;

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_LD    = 32'h0000B103;
  localparam logic [31:0] I_ADD   = 32'h002101B3;
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
  localparam logic [31:0] I_ADDIW = 32'h0010809B;
  localparam logic [31:0] I_SUB   = 32'h407302B3;
  localparam logic [31:0] I_LUI   = 32'h80000537;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_SW    = 32'hFE20AE23;

  function automatic out_t mk(input logic [63:0] pc, input logic [8:0] rd, input logic rdw,
                              input logic [63:0] imm, input logic [3:0] alu, input logic [2:0] f3,
                              input logic s1, input logic s2, input logic [5:0] fl);
    out_t e;
    e.valid = 1'b1; e.pc = pc; e.rd = rd; e.rdw = rdw; e.imm = imm; e.alu = alu; e.f3 = f3;
    e.s1pc = s1; e.s2imm = s2;
    {e.mr, e.mw, e.br, e.j, e.w, e.ill} = fl;
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic v,
                       input logic fl, input logic st, input logic rst);
    instr_in = ins; pc_in = pc; instr_valid_in = v; flush_in = fl; stall_in = st; reset_in = rst;
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    total++;
    assert (stall_out === exp) passed++;
    else $error("FAIL %s stall_out: observed %b expected %b", tag, stall_out, exp);
  endtask

  task automatic chk9(input string tag, input logic [8:0] o, input logic [8:0] exp);
    total++;
    assert (o === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, o, exp);
  endtask

  // Check combinational stall, queue the edge's expectation, clock, then pop and compare.
  task automatic tick(input string tag, input logic exp_stall, input out_t e, input out_t m);
    sb_t s, got;
    #1;
    chk_stall(tag, exp_stall);
    s.e = e; s.m = m;
    sb_q.push_back(s);
    last_e = e; last_m = m;
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    total++;
    assert ((obs & got.m) === (got.e & got.m)) passed++;
    else $error("FAIL %s outputs: observed %h expected %h", tag, obs & got.m, got.e & got.m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zero = '0;
    m_full = '1;
    m_flags = '0;
    m_flags.valid = 1'b1; m_flags.rdw = 1'b1;
    {m_flags.mr, m_flags.mw, m_flags.br, m_flags.j, m_flags.w, m_flags.ill} = 6'h3F;
    m_noalu_rd = '1; m_noalu_rd.alu = 4'd0; m_noalu_rd.rd = 9'd0;
    m_amb = '1; m_amb.alu = 4'd0; m_amb.s1pc = 1'b0; m_amb.s2imm = 1'b0;

    drive(32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("reset0", 1'b0, zero, m_full);
    tick("reset1", 1'b0, zero, m_full);

    drive(I_ADDI, 64'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk9("rs1_out addi", rs1_out, 9'd0);
    chk9("rs2_out addi", rs2_out, 9'd5);
    tick("addi", 1'b0, mk(64'h100, 9'd1, 1'b1, 64'd5, 4'd0, 3'd0, 1'b0, 1'b1, 6'b000000), m_full);

    drive(I_LD, 64'h104, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk9("rs1_out ld", rs1_out, 9'd1);
    tick("ld", 1'b0, mk(64'h104, 9'd2, 1'b1, 64'd0, 4'd0, 3'd3, 1'b0, 1'b1, 6'b100000), m_full);
    drive(I_ADD, 64'h108, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("load-use bubble", 1'b1, zero, m_flags);
    tick("add after bubble", 1'b0, mk(64'h108, 9'd3, 1'b1, 64'd0, 4'd0, 3'd0, 1'b0, 1'b0, 6'b000000), m_full);

    drive(I_BEQ, 64'h10C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("beq", 1'b0, mk(64'h10C, 9'd0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 4'd0, 3'd0, 1'b0, 1'b0, 6'b001000), m_noalu_rd);

    drive(32'h00000000, 64'h110, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("illegal zero", 1'b0, mk(64'h110, 9'd0, 1'b0, 64'd0, 4'd0, 3'd0, 1'b0, 1'b0, 6'b000001), m_flags);

    drive(I_LD, 64'h114, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("ld2", 1'b0, mk(64'h114, 9'd2, 1'b1, 64'd0, 4'd0, 3'd3, 1'b0, 1'b1, 6'b100000), m_full);
    drive(I_ADD, 64'h118, 1'b1, 1'b1, 1'b0, 1'b0);
    tick("flush over hazard", 1'b0, zero, m_flags);

`ifdef DECODE_WORD_OPS_EN
    drive(I_ADDIW, 64'h118, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("addiw", 1'b0, mk(64'h118, 9'd1, 1'b1, 64'd1, 4'd0, 3'd0, 1'b0, 1'b1, 6'b000010), m_full);
`else
    drive(I_ADDIW, 64'h118, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("addiw illegal", 1'b0, mk(64'h118, 9'd0, 1'b0, 64'd0, 4'd0, 3'd0, 1'b0, 1'b0, 6'b000001), m_flags);
`endif

    drive(I_ADDI, 64'h11C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("addi pre-stall", 1'b0, mk(64'h11C, 9'd1, 1'b1, 64'd5, 4'd0, 3'd0, 1'b0, 1'b1, 6'b000000), m_full);
    drive(I_SUB, 64'h120, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) tick("stall hold", 1'b1, last_e, last_m);
    drive(I_SUB, 64'h120, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("sub after stall", 1'b0, mk(64'h120, 9'd5, 1'b1, 64'd0, 4'd1, 3'd0, 1'b0, 1'b0, 6'b000000), m_full);

    drive(I_LUI, 64'h124, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("lui", 1'b0, mk(64'h124, 9'd10, 1'b1, 64'hFFFFFFFF80000000, 4'd0, 3'd0, 1'b0, 1'b0, 6'b000000), m_amb);
    drive(I_JAL, 64'h128, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("jal", 1'b0, mk(64'h128, 9'd1, 1'b1, 64'd8, 4'd0, 3'd0, 1'b0, 1'b0, 6'b000100), m_amb);
    drive(I_SW, 64'h12C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("sw", 1'b0, mk(64'h12C, 9'd0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 4'd0, 3'd2, 1'b0, 1'b1, 6'b010000), m_noalu_rd);

    drive(I_LD, 64'h130, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("ld3", 1'b0, mk(64'h130, 9'd2, 1'b1, 64'd0, 4'd0, 3'd3, 1'b0, 1'b1, 6'b100000), m_full);
    drive(I_SW, 64'h134, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("rs2 load-use bubble", 1'b1, zero, m_flags);
    tick("sw after bubble", 1'b0, mk(64'h134, 9'd0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 4'd0, 3'd2, 1'b0, 1'b1, 6'b010000), m_noalu_rd);

    drive(I_LD, 64'h200, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("ld4", 1'b0, mk(64'h200, 9'd2, 1'b1, 64'd0, 4'd0, 3'd3, 1'b0, 1'b1, 6'b100000), m_full);
    drive(I_ADD, 64'h204, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk_stall("hazard before reset", 1'b1);
    drive(I_ADD, 64'h204, 1'b1, 1'b0, 1'b0, 1'b1);
    tick("reset mid-hazard", 1'b0, zero, m_full);

    drive(I_ADDI, 64'h208, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("no instr valid", 1'b0, zero, m_flags);

    drive(I_LD, 64'h300, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("ld5", 1'b0, mk(64'h300, 9'd2, 1'b1, 64'd0, 4'd0, 3'd3, 1'b0, 1'b1, 6'b100000), m_full);
    drive(I_ADDI, 64'h304, 1'b1, 1'b0, 1'b0, 1'b0);
    tick("independent after load", 1'b0, mk(64'h304, 9'd1, 1'b1, 64'd5, 4'd0, 3'd0, 1'b0, 1'b1, 6'b000000), m_full);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and reset_in.
REQ-002 Ports, in order:
  clk  in  1  rising-edge clock.
  reset_in  in  1  synchronous active-high reset.
  stall_in  in  1  downstream hold; same signal that feeds the register file's stall_in.
  flush_in  in  1  kill the instruction being decoded (branch redirect).
  instr_valid_in  in  1  instr_in/pc_in valid from fetch.
  instr_in  in  32  RV64I instruction word.
  pc_in  in  64  instruction address.
  rs1_out, rs2_out  out  9  register-file read indices, combinational from instr_in[19:15]/[24:20], zero-extended.
  stall_out  out  1  fetch must hold instr_in.
  valid_out  out  1  decoded instruction valid.
  pc_out  out  64  registered pc.
  rd_out  out  9  destination index, zero-extended.
  rd_write_out  out  1  writes rd, forced 0 when rd==0.
  imm_out  out  64  sign-extended immediate.
  alu_op_out  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9.
  funct3_out  out  3  branch condition / memory width.
  src1_pc_out, src2_imm_out  out  1  ALU operand selects.
  mem_read_out, mem_write_out, branch_out, jump_out, word_out, illegal_out  out  1  class flags.

Function
REQ-003 Decoded outputs SHALL be registered; valid_out rises the cycle after instr_in is accepted, aligned with the register file's registered rs1/rs2 values.
REQ-004 Update priority per edge SHALL be: reset_in > flush_in > stall_in > load-use bubble > load new instruction.
REQ-005 stall_in=1 SHALL hold every registered output unchanged.
REQ-006 Load-use hazard: valid_out=1, mem_read_out=1, rd_out!=0, instr_valid_in=1, and rd_out equals a used rs1_out or rs2_out (per format) SHALL assert stall_out combinationally; next edge loads a bubble (valid_out=0), instruction not consumed.
REQ-007 stall_out SHALL also equal stall_in; SHALL be 0 while flush_in=1.
REQ-008 flush_in=1 SHALL load valid_out=0 regardless of instr_valid_in or hazard.
REQ-009 instr_valid_in=0 with no stall SHALL load valid_out=0.
REQ-010 Immediates SHALL follow I/S/B/U/J formats, bit 31 sign-extended to 64; R-type imm_out=0.
REQ-011 Opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP SHALL decode; any other opcode, or bits[1:0]!=11, SHALL set illegal_out=1, rd_write_out=0, mem_write_out=0.
REQ-012 When valid_out=0, all class flags and rd_write_out SHALL be 0.

Reset
REQ-013 reset_in=1 SHALL clear every registered output to 0 on the next edge; stall_out=0 during reset, including mid-hazard.

Configuration
REQ-014 Macro DECODE_WORD_OPS_EN: defined -> OP-IMM-32 (0011011) and OP-32 (0111011) decode with word_out=1; undefined -> both opcodes set illegal_out=1 and word_out is constant 0.

Verification
REQ-015 0x00500093 (addi x1,x0,5) -> next cycle valid_out=1, rd_out=1, rd_write_out=1, imm_out=5, alu_op_out=0, src2_imm_out=1.
REQ-016 0x0000B103 (ld x2,0(x1)) then 0x002101B3 (add x3,x2,x2) -> stall_out=1 one cycle, one valid_out=0 bubble, then add decoded with alu_op_out=0.
REQ-017 0xFE000EE3 (beq x0,x0,-4) -> branch_out=1, imm_out=0xFFFFFFFFFFFFFFFC, funct3_out=0, rd_write_out=0.
REQ-018 0x00000000 -> illegal_out=1, rd_write_out=0; flush_in=1 same cycle as valid instruction -> valid_out=0 next cycle.
REQ-019 0x0010809B (addiw x1,x1,1) -> with macro word_out=1, imm_out=1; without illegal_out=1.
REQ-020 stall_in=1 for 3 cycles mid-stream -> outputs constant; reset_in during hazard -> all outputs 0, stall_out=0.
